button_event_encoder: RTL and testbench

BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

---
 rtl/button_pkg.sv | 16 +
 rtl/event_fifo.sv | 60 ++++++
 rtl/button_event_encoder.sv | 102 ++++++++++
 tb/tb_button_event_encoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and defaults for the button event encoder
package button_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic       pressed;
    logic [2:0] idx;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - first-word-fall-through event queue with drop-on-full overflow pulse
module event_fifo
  import button_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   push,
  input  event_t push_data,
  input  logic   pop,
  output event_t head,
  output logic   full,
  output logic   empty,
  output logic   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A pop on the same edge frees the slot, so a push into a full queue still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset; present zero whenever nothing valid is queued.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/button_event_encoder.sv
// rtl/button_event_encoder.sv - turns 8-button snapshot changes into queued press/release events
module button_event_encoder
  import button_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] buttons,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [3:0] event_data,
  output logic       overflow
);

  logic [7:0] sync1;
  logic [7:0] synced;
  logic [7:0] prev;
  logic [7:0] snap;
  logic [7:0] diff;
  logic [2:0] idx;
  state_t     state;
  state_t     state_next;
  logic       push_q;
  event_t     push_ev;
  event_t     head;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1  <= 8'hFF;
      synced <= 8'hFF;
    end else begin
      sync1  <= buttons;
      synced <= sync1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (synced != prev) state_next = SCAN;
      SCAN:    if (idx == 3'd7)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each scanned bit is registered before entering the queue, adding one cycle of latency.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev    <= 8'hFF;
      snap    <= 8'hFF;
      diff    <= 8'h00;
      idx     <= 3'd0;
      push_q  <= 1'b0;
      push_ev <= '0;
    end else begin
      push_q <= 1'b0;
      case (state)
        IDLE: begin
          if (synced != prev) begin
            snap <= synced;
            diff <= synced ^ prev;
            idx  <= 3'd0;
          end
        end
        SCAN: begin
          push_q          <= diff[idx];
          push_ev.pressed <= ~snap[idx];
          push_ev.idx     <= idx;
          idx             <= idx + 3'd1;
          if (idx == 3'd7) prev <= snap;
        end
        default: ;
      endcase
    end
  end

  event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_event_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push_q),
    .push_data(push_ev),
    .pop      (event_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign event_valid = ~fifo_empty;
  assign event_data  = head;

endmodule

// File: tb/tb_button_event_encoder.sv
// tb/tb_button_event_encoder.sv - self-checking bench for button_event_encoder
module tb_button_event_encoder;
  import button_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] buttons = 8'hFF;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [3:0] event_data;
  logic       overflow;

  button_event_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .buttons    (buttons),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_data (event_data),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: every accepted change schedules its events at fixed future edges.
  logic [3:0] mq[$];
  logic [4:0] m_sched[16];
  logic [7:0] m_prev, m_d1, m_d2;
  int         m_edge = 0;
  int         m_free = 0;
  logic       m_ovf;
  logic [3:0] seen[$];

  typedef struct {
    logic [7:0] b;
    logic       r;
    logic       v;
    logic [3:0] d;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 16; i++) m_sched[i] = '0;
    m_prev = 8'hFF;
    m_d1   = 8'hFF;
    m_d2   = 8'hFF;
    m_free = m_edge;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] b, input logic r);
    logic       pop;
    logic       full;
    logic [4:0] ent;
    pop = (mq.size() > 0) && r;
    ent = m_sched[m_edge % 16];
    m_sched[m_edge % 16] = '0;
    if (m_edge >= m_free && m_d2 != m_prev) begin
      for (int k = 0; k < 8; k++)
        if (m_d2[k] != m_prev[k]) m_sched[(m_edge + 2 + k) % 16] = {1'b1, ~m_d2[k], 3'(k)};
      m_prev = m_d2;
      m_free = m_edge + 9;
    end
    full  = (mq.size() == DEPTH);
    m_ovf = 1'b0;
    if (pop) void'(mq.pop_front());
    if (ent[4]) begin
      if (full && !pop) m_ovf = 1'b1;
      else mq.push_back(ent[3:0]);
    end
    m_d2 = m_d1;
    m_d1 = b;
    m_edge++;
  endtask

  task automatic step(input logic [7:0] b, input logic r);
    buttons     = b;
    event_ready = r;
    @(posedge clk);
    if (n_rst) model_edge(b, r);
    else begin
      m_edge++;
      model_reset();
    end
    @(negedge clk);
    check("model_valid", 32'(event_valid), 32'(mq.size() > 0));
    check("model_data", 32'(event_data), 32'((mq.size() > 0) ? mq[0] : 4'h0));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step_rec(input logic [7:0] b, input logic r);
    step(b, r);
    if (event_valid) seen.push_back(event_data);
  endtask

  logic [3:0] exp_multi[4];
  logic [3:0] exp_full[8];
  int         ovf_cnt;
  logic [7:0] rb;

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{8'hFE, 1'b1, (i == 4), (i == 4) ? 4'h8 : 4'h0};
    exp_multi = '{4'h8, 4'hA, 4'hD, 4'hF};
    exp_full  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(event_valid), 32'h0);
    check("reset_data", 32'(event_data), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    n_rst = 1'b1;
    repeat (4) step(8'hFF, 1'b0);

    // single press, latency and pop
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].b, tbl[i].r);
      check("press_valid", 32'(event_valid), 32'(tbl[i].v));
      check("press_data", 32'(event_data), 32'(tbl[i].d));
    end

    // several presses in one scan, ascending order
    repeat (14) step(8'hFF, 1'b1);
    repeat (12) step(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("multi_valid", 32'(event_valid), 32'h1);
      check("multi_data", 32'(event_data), 32'(exp_multi[i]));
      step(8'h5A, 1'b1);
    end
    check("multi_count", 32'(event_valid), 32'h0);

    // eight releases fill the queue exactly, the next press overflows
    repeat (20) step(8'h00, 1'b1);
    ovf_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(8'hFF, 1'b0);
      if (overflow) ovf_cnt++;
    end
    check("fill_no_overflow", 32'(ovf_cnt), 32'h0);
    check("fill_head", 32'(event_data), 32'h0);
    for (int i = 0; i < 14; i++) begin
      step(8'hFE, 1'b0);
      if (overflow) ovf_cnt++;
    end
    check("overflow_pulses", 32'(ovf_cnt), 32'h1);

    // push into a full queue on the same edge as a pop
    repeat (7) step(8'hF6, 1'b0);
    step(8'hF6, 1'b1);
    check("fullpop_overflow", 32'(overflow), 32'h0);
    check("fullpop_head", 32'(event_data), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("fullpop_valid", 32'(event_valid), 32'h1);
      check("fullpop_data", 32'(event_data), 32'(exp_full[i]));
      step(8'hF6, 1'b1);
    end
    check("fullpop_count", 32'(event_valid), 32'h0);

    // change during a scan is picked up by the following scan
    repeat (20) step(8'hFF, 1'b1);
    seen.delete();
    repeat (4) step_rec(8'hFE, 1'b1);
    repeat (30) step_rec(8'hFC, 1'b1);
    check("midscan_count", 32'(seen.size()), 32'h2);
    if (seen.size() == 2) begin
      check("midscan_first", 32'(seen[0]), 32'h8);
      check("midscan_second", 32'(seen[1]), 32'h9);
    end

    // reset in the middle of a scan with two events queued
    repeat (20) step(8'hFF, 1'b1);
    repeat (6) step(8'hFC, 1'b0);
    check("prereset_valid", 32'(event_valid), 32'h1);
    check("prereset_data", 32'(event_data), 32'h8);
    n_rst   = 1'b0;
    buttons = 8'hFF;
    model_reset();
    #1;
    check("midreset_valid", 32'(event_valid), 32'h0);
    check("midreset_data", 32'(event_data), 32'h0);
    @(negedge clk);
    repeat (2) step(8'hFF, 1'b0);
    n_rst = 1'b1;
    seen.delete();
    repeat (20) step_rec(8'hFF, 1'b1);
    check("postreset_quiet", 32'(seen.size()), 32'h0);
    repeat (10) step_rec(8'hFE, 1'b1);
    check("postreset_count", 32'(seen.size()), 32'h1);
    if (seen.size() == 1) check("postreset_event", 32'(seen[0]), 32'h8);

    // random traffic against the reference, slow then fast consumer
    rb = 8'hFE;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) rb = 8'($urandom);
      if (i < 400) step(rb, $urandom_range(0, 3) == 0);
      else         step(rb, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
